// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: the IF/ID instruction and branch
// resolution in, pipeline enables, flush/bubble controls and stall stats out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      IF_ID_IR;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output IF_ID_IR,
    output branch_taken,
    input  pc_write,
    input  if_id_write,
    input  if_id_flush,
    input  id_ex_bubble,
    input  stall,
    input  stall_count
  );

  modport slave (
    input  IF_ID_IR,
    input  branch_taken,
    output pc_write,
    output if_id_write,
    output if_id_flush,
    output id_ex_bubble,
    output stall,
    output stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller beside ID of a 5-stage MIPS pipe.
// Shadows dest regs of EX/MEM/WB and stalls or flushes the front end.
module hazard_ctrl #(
  parameter bit FWD       = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       ld;
  } sb_t;

  sb_t              r_ex;
  sb_t              r_mem;
  sb_t              r_wb;
  sb_t              w_dec;
  logic [CNT_W-1:0] r_cnt;

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_nop;
  logic       w_is_r;
  logic       w_is_lw;
  logic       w_is_st;
  logic       w_use_rs;
  logic       w_use_rt;
  logic       w_hit_ex;
  logic       w_hit_mem;
  logic       w_hit_wb;
  logic       w_haz;
  logic       w_stall;

  assign w_op    = hz.IF_ID_IR[31:26];
  assign w_rs    = hz.IF_ID_IR[25:21];
  assign w_rt    = hz.IF_ID_IR[20:16];
  assign w_rd    = hz.IF_ID_IR[15:11];
  assign w_nop   = (hz.IF_ID_IR == 32'h0);
  assign w_is_r  = (w_op == 6'h00);
  assign w_is_lw = (w_op == 6'h23);
  assign w_is_st = (w_op == 6'h2B) || (w_op == 6'h04);

  always_comb begin
    w_dec    = '0;
    w_use_rs = !w_nop;
    w_use_rt = 1'b0;
    unique case (1'b1)
      w_is_r: begin
        w_use_rt = !w_nop;
        w_dec.d  = w_rd;
        w_dec.v  = !w_nop && (w_rd != 5'd0);
      end
      w_is_lw: begin
        w_dec.d  = w_rt;
        w_dec.ld = 1'b1;
        w_dec.v  = (w_rt != 5'd0);
      end
      w_is_st: begin
        w_use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic hit(sb_t e, logic use_rs,
                               logic use_rt,
                               logic [4:0] rs,
                               logic [4:0] rt);
    return e.v && (e.d != 5'd0) &&
           ((use_rs && e.d == rs) ||
            (use_rt && e.d == rt));
  endfunction

  assign w_hit_ex  = hit(r_ex, w_use_rs, w_use_rt, w_rs, w_rt);
  assign w_hit_mem = hit(r_mem, w_use_rs, w_use_rt, w_rs, w_rt);
  assign w_hit_wb  = hit(r_wb, w_use_rs, w_use_rt, w_rs, w_rt);

  always_comb begin
    w_haz = 1'b0;
    if (FWD) begin
      w_haz = w_hit_ex && r_ex.ld;
    end else begin
      w_haz = w_hit_ex || w_hit_mem ||
              (!WB_BYPASS && w_hit_wb);
    end
  end

  // reset and branch both outrank the hazard
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    w_stall         = 1'b0;
    if (reset) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (hz.branch_taken) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (w_haz) begin
      w_stall         = 1'b1;
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end
  end

  assign hz.stall       = w_stall;
  assign hz.stall_count = r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= hz.branch_taken ? '0 : r_ex;
      r_ex  <= (w_stall || hz.branch_taken) ? '0 : w_dec;
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations driven in lockstep,
// directed tables/sequences plus random traffic against a history model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir  = 32'h0;
  logic        br  = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hz0 ();
  hazard_ctrl_if #(.CNT_W(4))  hz1 ();
  hazard_ctrl_if #(.CNT_W(16)) hz2 ();

  assign hz0.IF_ID_IR = ir;
  assign hz1.IF_ID_IR = ir;
  assign hz2.IF_ID_IR = ir;
  assign hz0.branch_taken = br;
  assign hz1.branch_taken = br;
  assign hz2.branch_taken = br;

  hazard_ctrl #(.FWD(1'b1), .WB_BYPASS(1'b1), .CNT_W(16)) u0 (
    .clock(clk), .reset(rst), .hz(hz0));
  hazard_ctrl #(.FWD(1'b0), .WB_BYPASS(1'b1), .CNT_W(4)) u1 (
    .clock(clk), .reset(rst), .hz(hz1));
  hazard_ctrl #(.FWD(1'b0), .WB_BYPASS(1'b0), .CNT_W(16)) u2 (
    .clock(clk), .reset(rst), .hz(hz2));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a log of issued instructions stamped by cycle.
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       ld;
  } rec_t;

  rec_t iss[3][1024];
  int   cyc      = 0;
  int   last_rst = -1;
  int   mcnt[3]  = '{0, 0, 0};
  int   mmax[3]  = '{65535, 15, 65535};

  logic [4:0] smp_out[3];
  int         smp_cnt[3];

  function automatic void decode(input logic [31:0] x,
                                 output bit [4:0] s1,
                                 output bit [4:0] s2,
                                 output bit [4:0] dst,
                                 output bit ld);
    s1 = 0; s2 = 0; dst = 0; ld = 0;
    if (x == 32'h0) return;
    s1 = x[25:21];
    case (x[31:26])
      6'h00: begin s2 = x[20:16]; dst = x[15:11]; end
      6'h23: begin dst = x[20:16]; ld = 1; end
      6'h2B, 6'h04: s2 = x[20:16];
      default: ;
    endcase
  endfunction

  // k=0: forwarding; k=1: no fwd, WB bypass; k=2: no fwd, no bypass
  function automatic bit model_haz(int k);
    bit [4:0] s1, s2, dst;
    bit ld, h;
    decode(ir, s1, s2, dst, ld);
    h = 0;
    for (int d = 1; d <= 3; d++) begin
      int s;
      rec_t r;
      s = cyc - d;
      if (s >= 0 && s > last_rst) begin
        r = iss[k][s % 1024];
        if (r.v && r.d != 0 && (r.d == s1 || r.d == s2)) begin
          if (k == 0) h |= (d == 1) && r.ld;
          else if (k == 1) h |= (d <= 2);
          else h |= 1'b1;
        end
      end
    end
    return h;
  endfunction

  task automatic step(input logic [31:0] x, input bit b,
                      input bit r);
    logic [4:0] expv[3];
    bit [4:0] s1, s2, dst;
    bit ld;
    ir = x; br = b; rst = r;
    #3;
    smp_out[0] = {hz0.pc_write, hz0.if_id_write, hz0.if_id_flush,
                  hz0.id_ex_bubble, hz0.stall};
    smp_out[1] = {hz1.pc_write, hz1.if_id_write, hz1.if_id_flush,
                  hz1.id_ex_bubble, hz1.stall};
    smp_out[2] = {hz2.pc_write, hz2.if_id_write, hz2.if_id_flush,
                  hz2.id_ex_bubble, hz2.stall};
    smp_cnt[0] = int'(hz0.stall_count);
    smp_cnt[1] = int'(hz1.stall_count);
    smp_cnt[2] = int'(hz2.stall_count);
    for (int k = 0; k < 3; k++) begin
      if (r) expv[k] = 5'b00110;
      else if (b) expv[k] = 5'b11110;
      else if (model_haz(k)) expv[k] = 5'b00011;
      else expv[k] = 5'b11000;
      chk($sformatf("model outs u%0d cyc%0d", k, cyc),
          int'(smp_out[k]), int'(expv[k]));
      chk($sformatf("model count u%0d cyc%0d", k, cyc),
          smp_cnt[k], mcnt[k]);
    end
    decode(x, s1, s2, dst, ld);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) mcnt[k] = 0;
      else if (expv[k][0]) mcnt[k] = (mcnt[k] < mmax[k]) ?
                                     mcnt[k] + 1 : mmax[k];
      if (!r && !b && !expv[k][0])
        iss[k][cyc % 1024] = '{dst != 0, dst, ld};
      else
        iss[k][cyc % 1024] = '{0, 0, 0};
      if (!r && b && cyc >= 1) iss[k][(cyc - 1) % 1024].v = 0;
    end
    if (r) last_rst = cyc;
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] rins(int rs, int rt, int rd,
                                       int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'(fn)};
  endfunction

  function automatic logic [31:0] lwi(int rs, int rt);
    return {6'h23, 5'(rs), 5'(rt), 16'h0004};
  endfunction

  typedef struct {
    logic [31:0] ir;
    bit          br;
    bit          rst;
    logic [4:0]  outs;
    int          cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, stall}
    tbl[0]  = '{32'h0,            0, 1, 5'b00110, 0};
    tbl[1]  = '{lwi(1, 2),        0, 0, 5'b11000, 0};
    tbl[2]  = '{rins(2, 4, 3, 32), 0, 0, 5'b00011, 0};
    tbl[3]  = '{rins(2, 4, 3, 32), 0, 0, 5'b11000, 1};
    tbl[4]  = '{rins(1, 1, 2, 32), 0, 0, 5'b11000, 1};
    tbl[5]  = '{rins(2, 2, 3, 32), 0, 0, 5'b11000, 1};
    tbl[6]  = '{lwi(1, 0),        0, 0, 5'b11000, 1};
    tbl[7]  = '{rins(0, 0, 3, 32), 0, 0, 5'b11000, 1};
    tbl[8]  = '{lwi(1, 2),        0, 0, 5'b11000, 1};
    tbl[9]  = '{rins(2, 4, 3, 32), 1, 0, 5'b11110, 1};
    tbl[10] = '{rins(2, 4, 3, 32), 0, 0, 5'b11000, 1};

    step(32'h0, 0, 1);
    step(32'h0, 0, 1);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].ir, tbl[i].br, tbl[i].rst);
      chk($sformatf("table outs row%0d", i),
          int'(smp_out[0]), int'(tbl[i].outs));
      chk($sformatf("table count row%0d", i),
          smp_cnt[0], tbl[i].cnt);
    end

    // no forwarding: ALU result must reach the register file first
    step(32'h0, 0, 1);
    step(rins(1, 1, 5, 32), 0, 0);
    step(rins(5, 7, 6, 34), 0, 0);
    chk("nofwd stall c1", int'(smp_out[1][0]), 1);
    step(rins(5, 7, 6, 34), 0, 0);
    chk("nofwd stall c2", int'(smp_out[1][0]), 1);
    step(rins(5, 7, 6, 34), 0, 0);
    chk("nofwd issue c3", int'(smp_out[1][0]), 0);
    chk("nofwd nobypass stall c3", int'(smp_out[2][0]), 1);
    step(32'h0, 0, 0);
    chk("nofwd count", smp_cnt[1], 2);

    // reset landing on the second stall cycle
    step(32'h0, 0, 1);
    step(rins(1, 1, 5, 32), 0, 0);
    step(rins(5, 7, 6, 34), 0, 0);
    chk("rst-mid stall c1", int'(smp_out[1][0]), 1);
    step(rins(5, 7, 6, 34), 0, 1);
    chk("rst-mid forced outs", int'(smp_out[1]), 5'b00110);
    step(rins(5, 7, 6, 34), 0, 0);
    chk("rst-mid post stall", int'(smp_out[1][0]), 0);
    chk("rst-mid post count", smp_cnt[1], 0);
    step(32'h0, 0, 0);

    // self-dependent instruction held in IF/ID: repeated stalls
    step(32'h0, 0, 1);
    for (int i = 0; i < 30; i++) step(rins(5, 5, 5, 32), 0, 0);
    step(32'h0, 0, 0);
    chk("sat count cnt4", smp_cnt[1], 15);
    chk("sat count cnt16", smp_cnt[2], 22);
    chk("sat count fwd", smp_cnt[0], 0);

    step(32'h0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic [31:0] x;
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h00;
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        default: op = 6'h08;
      endcase
      x = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 11'($urandom_range(0, 63))};
      if ($urandom_range(0, 15) == 0) x = 32'h0;
      step(x, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS pipeline. Sits beside the instruction-decode stage.
- Watches the instruction held in the IF/ID latch.
- Keeps a 3-deep shadow scoreboard of destination registers for the instructions in EX, MEM and WB.
- Drives PC/IF-ID write enables, the ID/EX bubble insert, the IF/ID flush and a stall performance counter.

Parameters:
- FWD, 1, 1 = forwarding exists: stall only on load-use against EX; 0 = stall on any RAW match in EX/MEM/WB.
- WB_BYPASS, 1, 1 = register file writes before reads, so a WB match never stalls (used only when FWD=0).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- IF_ID_IR  in  32  instruction currently in IF/ID
- branch_taken  in  1  taken branch resolved in MEM this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID latch enable
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_bubble  out  1  force CTR_bits to 0 into ID/EX on next edge
- stall  out  1  hazard stall active this cycle
- stall_count  out  CNT_W  stall cycles since reset, saturating

Behaviour:
- Decode (combinational from IF_ID_IR[31:26]):
  - 0x00 R-type: src rs,rt; dest rd[15:11].
  - 0x23 lw: src rs; dest rt; load=1.
  - 0x2B sw: src rs,rt; no dest.
  - 0x04 beq: src rs,rt; no dest.
  - Any other opcode: src rs; no dest.
  - Register 0 is never a source or dest match. 32'h0 is a NOP.
- Scoreboard entries EX, MEM, WB each hold {valid, dest[4:0], load}.
- Each edge, when not in reset:
  - WB <= MEM.
  - MEM <= EX, or invalid if branch_taken.
  - EX <= decoded IF/ID entry, or invalid if stall or branch_taken.
- Hazard (combinational from registered scoreboard + IF_ID_IR):
  - FWD=1: haz = EX.valid & EX.load & (EX.dest matches a used src).
  - FWD=0: haz = a match in EX or MEM, or in WB when WB_BYPASS=0.
- Outputs, combinational, in priority order:
  - branch_taken = 1: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1, stall=0. Branch overrides any hazard.
  - Else haz = 1: stall=1, pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - Else: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, stall=0.
- Latency:
  - Stall is asserted in the same cycle the dependent instruction sits in IF/ID.
  - A load-use stall lasts exactly 1 cycle with FWD=1.
  - With FWD=0 and WB_BYPASS=1, a stall lasts up to 2 cycles; with WB_BYPASS=0, up to 3 cycles.
- stall_count: increments on each edge where stall=1. Holds at all-ones (2^CNT_W-1), with no wrap.
- Reset (synchronous):
  - All scoreboard entries become invalid and stall_count becomes 0.
  - While reset=1, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, stall=0.
  - Reset mid-stall discards all pending hazards. The first cycle after reset has no stall regardless of IF_ID_IR.
- Back-to-back: a stalled instruction is re-evaluated each cycle against the advancing scoreboard. The bubble it injects is an invalid EX entry.

Test Plan:
- FWD=1: lw $2,0($1) then add $3,$2,$4 -> stall=1 and id_ex_bubble=1 for exactly 1 cycle, pc_write=0 in that cycle, stall_count=1.
- FWD=1: add $2,$1,$1 then add $3,$2,$2 -> no stall. Also lw $0 then a use of $0 -> no stall.
- FWD=0, WB_BYPASS=1: add $5,... then sub $6,$5,$7 -> stall for 2 consecutive cycles, then issue; stall_count=2.
- branch_taken=1 in the same cycle as a load-use hazard -> if_id_flush=1, stall=0, and the EX/MEM entries are cleared next edge (no stall the following cycle).
- Reset asserted during the second stall cycle (FWD=0) -> stall_count=0 after the edge, scoreboard empty, and the same dependent instruction issues with no stall after reset drops.
- CNT_W=4: force 20 stall cycles -> stall_count saturates at 15.
